sram_result_checker: RTL

//  Hardware successor of the bench's software result check. Streams COUNT words from START_ADDR
//  out of a golden SRAM and the result SRAM, and compares them. The sign bit is masked and a

---
 rtl/sram_result_checker.sv | 86 ++++++++
 1 files changed

// File: rtl/sram_result_checker.sv
// sram_result_checker: streams golden/result SRAM words and compares them with sign masked and ULP tolerance
module sram_result_checker #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TOL_ULP    = 1,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chk_valid,
  output logic                  chk_ready,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  input  logic                  stop_on_fail,
  output logic [ADDR_WIDTH-1:0] golden_read_address,
  input  logic [DATA_WIDTH-1:0] golden_read_data,
  output logic [ADDR_WIDTH-1:0] result_read_address,
  input  logic [DATA_WIDTH-1:0] result_read_data,
  output logic [CNT_WIDTH-1:0]  elem_count,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic                  fail_seen,
  output logic [ADDR_WIDTH-1:0] first_fail_addr
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam logic [DATA_WIDTH-1:0] MASK = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr, addr_d;
  logic [CNT_WIDTH-1:0] rem;
  logic [DATA_WIDTH-1:0] g, r, diff;
  logic stop_r, cmp_v, pass, abort, accept, last;
  assign golden_read_address = addr;
  assign result_read_address = addr;
  always_comb begin
    g = golden_read_data & MASK;
    r = result_read_data & MASK;
    diff = g >= r ? g - r : r - g;
    pass = diff <= DATA_WIDTH'(TOL_ULP);
    accept = state == IDLE && chk_valid && chk_ready;
    abort = state == ISSUE && cmp_v && !pass && stop_r;
    last = rem == CNT_WIDTH'(1);
    state_nx = state == IDLE  ? (accept ? (word_count == '0 ? DONE : ISSUE) : IDLE) :
               state == ISSUE ? (abort ? DONE : (last ? DRAIN : ISSUE)) :
               state == DRAIN ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      chk_ready <= 1'b1;
      addr <= '0;
      addr_d <= '0;
      rem <= '0;
      stop_r <= 1'b0;
      cmp_v <= 1'b0;
      elem_count <= '0;
      match_count <= '0;
      fail_seen <= 1'b0;
      first_fail_addr <= '0;
    end else begin
      state <= state_nx;
      chk_ready <= state == IDLE && !accept;
      addr_d <= addr;
      cmp_v <= state == ISSUE && !abort;
      if (state == ISSUE && !abort) begin
        addr <= last ? addr : addr + ADDR_WIDTH'(1);
        rem <= rem - CNT_WIDTH'(1);
      end
      if (cmp_v) begin
        elem_count <= elem_count + CNT_WIDTH'(1);
        match_count <= match_count + CNT_WIDTH'(pass);
        if (!pass && !fail_seen) begin
          fail_seen <= 1'b1;
          first_fail_addr <= addr_d;
        end
      end
      if (accept) begin
        rem <= word_count;
        stop_r <= stop_on_fail;
        addr <= word_count == '0 ? addr : start_addr;
        elem_count <= '0;
        match_count <= '0;
        fail_seen <= 1'b0;
        first_fail_addr <= '0;
      end
    end
  end
endmodule
